// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults) and coordinate width.
// Also holds a small window-membership helper used for the sync pulses.
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int TICK_DIV_DEF  = 4;

    localparam int H_TOTAL = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // True when pos lies in [lo, lo+len-1].
    function automatic logic in_window(input logic [COORD_W-1:0] pos, input int lo, input int len);
        return (int'(pos) >= lo) && (int'(pos) < lo + len);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate enable: free-running wrap counter, p_tick high on its last count.
// TICK_DIV must be a power of two so the counter wraps naturally.
module pixel_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic p_tick
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] CNT_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TW'(1);
        end
    end

    assign p_tick = (cnt == CNT_LAST);

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: horizontal/vertical counters advanced on p_tick,
// registered active-low syncs and a one-clock frame_start pulse.
module vga_sync
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter int TICK_DIV  = TICK_DIV_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               p_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               frame_start
);

    localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOT - 1);

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic [COORD_W-1:0] h_next;
    logic [COORD_W-1:0] v_next;
    logic               h_wrap;
    logic               v_wrap;

    pixel_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .p_tick (p_tick)
    );

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        v_wrap = (v_cnt == V_LAST);
        h_next = h_cnt;
        v_next = v_cnt;
        if (p_tick) begin
            h_next = h_wrap ? '0 : h_cnt + COORD_W'(1);
            if (h_wrap) begin
                v_next = v_wrap ? '0 : v_cnt + COORD_W'(1);
            end
        end
    end

    // Syncs are decoded from the next-state counters so they change on the
    // same edge as pixel_x/pixel_y while still coming straight from flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            hsync       <= !in_window(h_next, H_DISPLAY + H_FRONT, H_SYNC);
            vsync       <= !in_window(v_next, V_DISPLAY + V_FRONT, V_SYNC);
            frame_start <= p_tick && h_wrap && v_wrap;
        end
    end

    assign pixel_x  = h_cnt;
    assign pixel_y  = v_cnt;
    assign video_on = (int'(h_cnt) < H_DISPLAY) && (int'(v_cnt) < V_DISPLAY);

endmodule
